// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM state type and line-level constants for the 8N1 transmitter
package uart_tx_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/tx_bit_timer.sv
// tx_bit_timer: bit-period counter; clr_i/en_i in, cnt_o count and roll_o strobe (cnt at last clock while enabled) out
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr_i,
  input  logic                            en_i,
  output logic [$clog2(CLKS_PER_BIT)-1:0] cnt_o,
  output logic                            roll_o
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  logic [TW-1:0] cnt_q, cnt_d;
  assign roll_o = en_i & (cnt_q == TW'(CLKS_PER_BIT - 1));
  assign cnt_d  = (clr_i | roll_o) ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  assign cnt_o  = cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: 8N1-style serial transmitter; tx_data/tx_start handshake in (tx_ready), serial_out/tx_busy/tx_done out
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_ready,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 tx_done
);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam int TW = $clog2(CLKS_PER_BIT);
  tx_state_t            state_q;
  logic [DATA_BITS-1:0] hold_q, shift_q;
  logic [IW-1:0]        idx_q;
  logic [TW-1:0]        cnt;
  logic                 hold_valid_q, hold_valid_d, ready_q, out_q;
  logic                 roll, accept, load;
  assign accept       = tx_start & ready_q;
  // hold buffer drains into the shift register from IDLE or on a stop-bit rollover
  assign load         = hold_valid_q & ((state_q == IDLE) | ((state_q == STOP) & roll));
  assign hold_valid_d = accept | (hold_valid_q & ~load);
  assign tx_ready     = ready_q;
  assign serial_out   = out_q;
  assign tx_busy      = state_q != IDLE;
  assign tx_done      = (state_q == STOP) & (cnt == TW'(CLKS_PER_BIT - 1));
  tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == IDLE),
    .en_i   (state_q != IDLE),
    .cnt_o  (cnt),
    .roll_o (roll)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      shift_q      <= '0;
      idx_q        <= '0;
      hold_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      out_q        <= IDLE_LEVEL;
    end else begin
      hold_valid_q <= hold_valid_d;
      ready_q      <= ~hold_valid_d;
      if (accept) hold_q <= tx_data;
      if (load) shift_q <= hold_q;
      case (state_q)
        IDLE: if (load) begin
          state_q <= START;
          out_q   <= START_BIT;
        end
        START: if (roll) begin
          state_q <= DATA;
          out_q   <= shift_q[0];
          idx_q   <= '0;
        end
        DATA: if (roll) begin
          shift_q <= shift_q >> 1;
          idx_q   <= (idx_q == IW'(DATA_BITS - 1)) ? '0 : idx_q + 1'b1;
          state_q <= (idx_q == IW'(DATA_BITS - 1)) ? STOP : DATA;
          out_q   <= (idx_q == IW'(DATA_BITS - 1)) ? STOP_BIT : shift_q[1];
        end
        STOP: if (roll) begin
          state_q <= load ? START : IDLE;
          out_q   <= load ? START_BIT : IDLE_LEVEL;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scoreboard bench for uart_tx_frame at default and minimal parameters
module tb_uart_tx_frame;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_start = 1'b0;
  logic       tx_ready, serial_out, tx_busy, tx_done;
  logic [4:0] tx_data2 = '0;
  logic       tx_start2 = 1'b0;
  logic       tx_ready2, serial_out2, tx_busy2, tx_done2;
  logic       exp_q[$];
  logic       exp;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_frame dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
    .tx_ready(tx_ready), .serial_out(serial_out), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx_frame #(.CLKS_PER_BIT(2), .DATA_BITS(5)) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_start(tx_start2),
    .tx_ready(tx_ready2), .serial_out(serial_out2), .tx_busy(tx_busy2), .tx_done(tx_done2)
  );

  task automatic push_frame(input logic [8:0] d, input int nb, input int cpb);
    for (int b = 0; b < nb + 2; b++)
      repeat (cpb) exp_q.push_back(b == 0 ? 1'b0 : b == nb + 1 ? 1'b1 : d[b-1]);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (serial_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: got out=%b rdy=%b busy=%b done=%b, want 1 1 0 0", serial_out, tx_ready, tx_busy, tx_done);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (serial_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got out=%b rdy=%b busy=%b, want 1 1 0", serial_out, tx_ready, tx_busy);
    end
    n_checks++; if (serial_out2 !== 1'b1 || tx_ready2 !== 1'b1 || tx_busy2 !== 1'b0) begin
      n_fail++; $display("FAIL reset_state_small: got out=%b rdy=%b busy=%b, want 1 1 0", serial_out2, tx_ready2, tx_busy2);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    tx_data = 8'hA5; tx_start = 1'b1; push_frame(9'h0A5, 8, 10);
    @(negedge clk);
    tx_start = 1'b0;
    n_checks++; if (tx_ready !== 1'b0 || serial_out !== 1'b1) begin
      n_fail++; $display("FAIL single_accept: got rdy=%b out=%b, want 0 1", tx_ready, serial_out);
    end
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++; if (serial_out !== exp) begin
        n_fail++; $display("FAIL single_line cycle %0d: got %b, want %b", c, serial_out, exp);
      end
      n_checks++; if (tx_done !== (c == 100)) begin
        n_fail++; $display("FAIL single_done cycle %0d: got %b, want %b", c, tx_done, c == 100);
      end
      n_checks++; if (tx_busy !== 1'b1) begin
        n_fail++; $display("FAIL single_busy cycle %0d: got %b, want 1", c, tx_busy);
      end
    end
    @(negedge clk);
    n_checks++; if (serial_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_idle: got out=%b busy=%b done=%b rdy=%b, want 1 0 0 1", serial_out, tx_busy, tx_done, tx_ready);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    tx_data = 8'h5A; tx_start = 1'b1; push_frame(9'h05A, 8, 10);
    @(negedge clk);
    tx_start = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++; if (serial_out !== exp) begin
        n_fail++; $display("FAIL midrst_line cycle %0d: got %b, want %b", c, serial_out, exp);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    n_checks++; if (serial_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_state: got out=%b rdy=%b busy=%b done=%b, want 1 1 0 0", serial_out, tx_ready, tx_busy, tx_done);
    end
    for (int c = 0; c < 110; c++) begin
      @(negedge clk);
      n_checks++; if (serial_out !== 1'b1 || tx_done !== 1'b0) begin
        n_fail++; $display("FAIL midrst_quiet cycle %0d: got out=%b done=%b, want 1 0", c, serial_out, tx_done);
      end
    end
  endtask

  task automatic test_back_to_back(input logic [7:0] a, input logic [7:0] b, input logic third);
    @(negedge clk);
    tx_data = a; tx_start = 1'b1; push_frame({1'b0, a}, 8, 10);
    @(negedge clk);
    tx_start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++; if (serial_out !== exp) begin
        n_fail++; $display("FAIL b2b_line cycle %0d: got %b, want %b", c, serial_out, exp);
      end
      n_checks++; if (tx_done !== (c == 100 || c == 200)) begin
        n_fail++; $display("FAIL b2b_done cycle %0d: got %b, want %b", c, tx_done, c == 100 || c == 200);
      end
      n_checks++; if (tx_busy !== 1'b1) begin
        n_fail++; $display("FAIL b2b_busy cycle %0d: got %b, want 1", c, tx_busy);
      end
      n_checks++; if (tx_ready !== (c < 5 || c > 100)) begin
        n_fail++; $display("FAIL b2b_ready cycle %0d: got %b, want %b", c, tx_ready, c < 5 || c > 100);
      end
      tx_start = 1'b0;
      if (c == 4) begin
        tx_data = b; tx_start = 1'b1; push_frame({1'b0, b}, 8, 10);
      end
      if (third && c >= 19 && c < 30) begin
        tx_data = 8'h3C; tx_start = 1'b1;
      end
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      n_checks++; if (serial_out !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_after cycle %0d: got out=%b busy=%b rdy=%b, want 1 0 1", c, serial_out, tx_busy, tx_ready);
      end
    end
    n_checks++; if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL b2b_queue: got %0d leftover bits, want 0", exp_q.size());
    end
  endtask

  task automatic test_small();
    @(negedge clk);
    tx_data2 = 5'b10011; tx_start2 = 1'b1; push_frame(9'b0_0001_0011, 5, 2);
    @(negedge clk);
    tx_start2 = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++; if (serial_out2 !== exp) begin
        n_fail++; $display("FAIL small_line cycle %0d: got %b, want %b", c, serial_out2, exp);
      end
      n_checks++; if (tx_done2 !== (c == 14)) begin
        n_fail++; $display("FAIL small_done cycle %0d: got %b, want %b", c, tx_done2, c == 14);
      end
    end
    @(negedge clk);
    n_checks++; if (serial_out2 !== 1'b1 || tx_busy2 !== 1'b0 || tx_ready2 !== 1'b1) begin
      n_fail++; $display("FAIL small_idle: got out=%b busy=%b rdy=%b, want 1 0 1", serial_out2, tx_busy2, tx_ready2);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid();
    test_back_to_back(8'h00, 8'hFF, 1'b0);
    test_back_to_back(8'h11, 8'h22, 1'b1);
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Serial transmitter; the transmit end of the same 8N1 serial link the receive-side timer/shift logic samples.
- Accepts bytes over a valid/ready handshake and buffers one pending byte.
- Emits each frame as a start bit (0), DATA_BITS data bits LSB-first, and one stop bit (1). Each bit lasts CLKS_PER_BIT clocks.
- Sits between the host-side byte source and the serial pin.

Parameters:
- CLKS_PER_BIT, 10, clocks per serial bit period; legal range >= 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- tx_data  input  DATA_BITS  byte to send; sampled only on an accepted handshake.
- tx_start  input  1  valid; the byte is accepted on an edge where tx_start & tx_ready.
- tx_ready  output  1  registered; high when the hold buffer is empty.
- serial_out  output  1  registered line output; idle high.
- tx_busy  output  1  high while a frame is on the line (states START, DATA, STOP).
- tx_done  output  1  one-cycle pulse during the final clock of each stop bit.

Behaviour:
- Reset:
  - Applies on any edge with rst=1, mid-frame included.
  - serial_out=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE.
  - Hold buffer is emptied, bit timer=0, bit index=0. Any in-flight frame is abandoned with no stop bit.
- Hold buffer:
  - Acceptance loads hold_reg and sets hold_valid. tx_ready = !hold_valid, registered.
  - A byte accepted while a frame is in flight waits in hold_reg.
  - hold_valid clears on the edge where hold_reg transfers into the shift register.
  - tx_ready is low on that edge, so acceptance and transfer never coincide.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: serial_out=1. If hold_valid, at the next edge: load shift_reg from hold_reg, clear hold_valid, go to START, drive serial_out=0, clear timer.
  - START: serial_out=0 for CLKS_PER_BIT cycles. On timer rollover, go to DATA with serial_out=shift_reg[0] and bit index=0.
  - DATA: serial_out=shift_reg[0]. On each rollover: shift right and increment the index. After bit DATA_BITS-1 rolls over, go to STOP with serial_out=1.
  - STOP: serial_out=1 for CLKS_PER_BIT cycles. tx_done=1 in the cycle where the timer equals CLKS_PER_BIT-1.
  - STOP rollover with hold_valid: go straight to START (back-to-back, no idle gap) and reload shift_reg.
  - STOP rollover without hold_valid: go to IDLE.
- Latency:
  - Handshake accepted at edge E0 from IDLE: serial_out falls at edge E1.
  - Frame spans (DATA_BITS+2)*CLKS_PER_BIT cycles (100 at defaults).
  - tx_done is high during the last of those cycles.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT), and wraps to 0.
  - Rollover strobe fires combinationally when count == CLKS_PER_BIT-1 and the timer is enabled.
  - Enabled in START, DATA and STOP; held at 0 in IDLE.
- Bit index: width $clog2(DATA_BITS+1); never exceeds DATA_BITS-1.
- tx_data is ignored when tx_start=0 or tx_ready=0. tx_start held high with tx_ready low has no effect.
- serial_out comes only from a register; no combinational path from inputs to serial_out.

Decomposition:
- Package uart_tx_pkg:
  - tx_state_t enum {IDLE, START, DATA, STOP}, 2-bit.
  - Constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
- Sub-module tx_bit_timer: parameterised counter with clear and enable inputs and count/rollover outputs, instanced once for bit-period timing.
- FSM, shift register, hold buffer and bit index stay in uart_tx_frame.

Test Plan:
- Reset mid-DATA (rst high one cycle at frame cycle 37) -> next edge serial_out=1, tx_ready=1, tx_busy=0; no tx_done; line stays 1 until a new handshake.
- Single byte 0xA5 from IDLE at defaults -> serial_out falls at E1. Line sequence per 10-cycle bit: 0, 1,0,1,0,0,1,0,1, 1. tx_done pulses once at cycle 100 after E1; then IDLE, tx_busy=0.
- Back-to-back 0x00 then 0xFF, the second accepted at frame cycle 5 -> tx_ready low from then until the second frame loads. Second start bit begins the cycle after the first stop bit's last cycle (no idle gap). Two tx_done pulses 100 cycles apart.
- Handshake attempted while the hold buffer is full (third byte 0x3C during the first frame) -> not accepted. Only the two earlier bytes are transmitted, and tx_ready rises again when the second byte loads.
- CLKS_PER_BIT=2, DATA_BITS=5, byte 5'b10011 -> frame of 14 cycles: 0,0, 1,1, 1,1, 0,0, 0,0, 1,1, 1,1. tx_done in cycle 14.
